// File: rtl/seq_divider.sv
// Sequential restoring divider producing one quotient bit per clock, signed or unsigned,
// with a short path that reports a zero divisor one cycle after start.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module seq_divider #(
   parameter int W = `DATAWIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sign,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [W-1:0]  rem;
   logic [W-1:0]  quo;
   logic [W-1:0]  dvsr;
   logic          neg_q;
   logic          neg_r;
   logic          zero_div;

   logic [W-1:0]  abs_dividend;
   logic [W-1:0]  abs_divisor;
   logic [W:0]    shifted;
   logic [W+1:0]  diff;
   logic          borrow;

   // A successful trial subtraction always leaves a value below the divisor,
   // so either of the top two difference bits set means the subtraction borrowed.
   always_comb begin
      abs_dividend = (sign && dividend[W-1]) ? -dividend : dividend;
      abs_divisor  = (sign && divisor[W-1])  ? -divisor  : divisor;
      shifted      = {rem, quo[W-1]};
      diff         = {1'b0, shifted} - {2'b00, dvsr};
      borrow       = |diff[W+1:W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_div    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !busy) begin
                  rem   <= '0;
                  dvsr  <= abs_divisor;
                  count <= CW'(W);
                  neg_q <= sign & (dividend[W-1] ^ divisor[W-1]);
                  neg_r <= sign & dividend[W-1];
                  // A zero divisor keeps the raw dividend in quo and skips CALC entirely.
                  if (divisor == '0) begin
                     zero_div <= 1'b1;
                     quo      <= dividend;
                     state    <= FIX;
                  end else begin
                     zero_div <= 1'b0;
                     quo      <= abs_dividend;
                     busy     <= 1'b1;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               quo   <= {quo[W-2:0], ~borrow};
               rem   <= borrow ? shifted[W-1:0] : diff[W-1:0];
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (zero_div) begin
                  quotient  <= '1;
                  remainder <= quo;
               end else begin
                  quotient  <= neg_q ? -quo : quo;
                  remainder <= neg_r ? -rem : rem;
               end
               div_by_zero <= zero_div;
               done        <= 1'b1;
               busy        <= 1'b0;
               count       <= '0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard testbench for seq_divider: expected results are queued when a start is
// driven and popped when done is observed.
module tb_seq_divider;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic         SIG_S [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [W-1:0] SIG_A [7] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'h00000007,
                                          32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFE};
   localparam logic [W-1:0] SIG_B [7] = '{32'h00000002, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                          32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};

   always #5 clk = ~clk;

   seq_divider #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .sign        (sign),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always @(negedge clk) begin
      if (busy === 1'b1 && done === 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_done_overlap got busy=1 done=1 want never both high");
      end
   end

   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.dz = (b == '0);
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (!s) begin
         e.q = a / b;
         e.r = a % b;
      end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
         e.q = a;
         e.r = '0;
      end else begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
      end
      return e;
   endfunction

   // Drives one start pulse, scrambles inputs after acceptance and waits (bounded) for done.
   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int cycles, output logic busy0);
      @(negedge clk);
      start    = 1'b1;
      sign     = s;
      dividend = a;
      divisor  = b;
      exp_q.push_back(model(s, a, b));
      @(negedge clk);
      start    = 1'b0;
      sign     = ~s;
      dividend = $urandom;
      divisor  = $urandom;
      busy0    = busy;
      cycles   = 0;
      while (done !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b1;
      dividend = 32'd5;
      divisor  = 32'd1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++; if (quotient !== '0) begin errors++; $display("[TB] FAIL reset_quotient got %h want 0", quotient); end
      checks++; if (remainder !== '0) begin errors++; $display("[TB] FAIL reset_remainder got %h want 0", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got %b want 0", div_by_zero); end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_basic();
      int   cyc;
      logic b0;
      exp_t e;
      run_op(1'b0, 32'd100, 32'd7, cyc, b0);
      e = exp_q.pop_front();
      checks++; if (cyc !== W + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", cyc, W + 1); end
      checks++; if (b0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", b0); end
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL basic_quotient got %h want %h", quotient, e.q); end
      checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL basic_remainder got %h want %h", remainder, e.r); end
      checks++; if (div_by_zero !== e.dz) begin errors++; $display("[TB] FAIL basic_dbz got %b want %b", div_by_zero, e.dz); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL basic_hold got %h want %h", quotient, e.q); end
   endtask

   task automatic test_signed();
      int   cyc;
      logic b0;
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         run_op(SIG_S[i], SIG_A[i], SIG_B[i], cyc, b0);
         e = exp_q.pop_front();
         checks++; if (cyc !== W + 1) begin errors++; $display("[TB] FAIL signed_latency[%0d] got %0d want %0d", i, cyc, W + 1); end
         checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL signed_quotient[%0d] got %h want %h", i, quotient, e.q); end
         checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL signed_remainder[%0d] got %h want %h", i, remainder, e.r); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL signed_dbz[%0d] got %b want 0", i, div_by_zero); end
      end
   endtask

   task automatic test_div_zero();
      int   cyc;
      logic b0;
      exp_t e;
      logic [W-1:0] a;
      for (int i = 0; i < 3; i++) begin
         a = (i == 2) ? 32'hFFFF0000 : 32'h00001234;
         run_op(i != 0, a, '0, cyc, b0);
         e = exp_q.pop_front();
         checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL dz_latency[%0d] got %0d want 1", i, cyc); end
         checks++; if (b0 !== 1'b0) begin errors++; $display("[TB] FAIL dz_busy[%0d] got %b want 0", i, b0); end
         checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL dz_quotient[%0d] got %h want %h", i, quotient, e.q); end
         checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL dz_remainder[%0d] got %h want %h", i, remainder, e.r); end
         checks++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag[%0d] got %b want 1", i, div_by_zero); end
      end
      run_op(1'b0, 32'd50, 32'd5, cyc, b0);
      e = exp_q.pop_front();
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL dz_clear got %b want 0", div_by_zero); end
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL dz_after_quotient got %h want %h", quotient, e.q); end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t e;
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd10;
      exp_q.push_back(model(1'b0, 32'd1000, 32'd10));
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 10) begin
            start = 1'b1; sign = 1'b1; dividend = 32'd77; divisor = 32'd5;
         end else begin
            start = 1'b0;
         end
      end
      e = exp_q.pop_front();
      checks++; if (cyc !== W + 1) begin errors++; $display("[TB] FAIL ignore_latency got %0d want %0d", cyc, W + 1); end
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL ignore_quotient got %h want %h", quotient, e.q); end
      checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL ignore_remainder got %h want %h", remainder, e.r); end
      start = 1'b1; sign = 1'b0; dividend = 32'd500; divisor = 32'd9;
      exp_q.push_back(model(1'b0, 32'd500, 32'd9));
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      e = exp_q.pop_front();
      checks++; if (cyc !== W + 1) begin errors++; $display("[TB] FAIL b2b_latency got %0d want %0d", cyc, W + 1); end
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL b2b_quotient got %h want %h", quotient, e.q); end
      checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL b2b_remainder got %h want %h", remainder, e.r); end
   endtask

   task automatic test_reset_mid();
      int   cyc;
      logic b0;
      logic seen;
      exp_t e;
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd12345; divisor = 32'd67;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ctrl got busy=%b done=%b want 0 0", busy, done); end
      checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("[TB] FAIL mid_reset_data got %h %h want 0 0", quotient, remainder); end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_no_done got %b want 0", seen); end
      run_op(1'b0, 32'd9, 32'd3, cyc, b0);
      e = exp_q.pop_front();
      checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL post_reset_quotient got %h want %h", quotient, e.q); end
      checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL post_reset_remainder got %h want %h", remainder, e.r); end
   endtask

   task automatic test_random();
      int           cyc;
      logic         b0;
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;
      for (int i = 0; i < 12; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = $urandom;
            default: b = -W'($urandom_range(1, 5));
         endcase
         run_op(s, a, b, cyc, b0);
         e = exp_q.pop_front();
         checks++; if (cyc !== (e.dz ? 1 : W + 1)) begin errors++; $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", i, cyc, e.dz ? 1 : W + 1); end
         checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL rand_quotient[%0d] got %h want %h", i, quotient, e.q); end
         checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL rand_remainder[%0d] got %h want %h", i, remainder, e.r); end
         checks++; if (div_by_zero !== e.dz) begin errors++; $display("[TB] FAIL rand_dbz[%0d] got %b want %b", i, div_by_zero, e.dz); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL use macro `datawidth, default 32 (from signle_clk_cpu/defines.v): operand/result width W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; operands sampled with it.
REQ-005 SHALL have port sign  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 SHALL have port dividend  input  W  numerator.
REQ-007 SHALL have port divisor  input  W  denominator.
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid from this cycle.
REQ-010 SHALL have port quotient  output  W  registered quotient.
REQ-011 SHALL have port remainder  output  W  registered remainder.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, set when divisor == 0.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; rst_n low forces IDLE.
REQ-014 SHALL accept start only in IDLE with busy low; start in CALC/FIX has no effect.
REQ-015 On accepted start (edge E0), SHALL latch |dividend|, |divisor| (abs only when sign=1), result-sign flags, clear partial remainder, load step counter = W, enter CALC.
REQ-016 In CALC, SHALL perform one restoring step per edge: shift {rem,quo} left 1, trial-subtract divisor from rem, keep difference and set quo LSB = 1 if no borrow, else restore and set LSB = 0; decrement counter.
REQ-017 Subtraction SHALL be W+1 bits wide so MSB-set unsigned operands never overflow.
REQ-018 After W CALC edges (E1..EW), SHALL enter FIX; at edge E(W+1) SHALL write quotient/remainder with sign correction, pulse done, return to IDLE.
REQ-019 Total latency SHALL be W+1 cycles from accepted start to done (33 for W=32).
REQ-020 busy SHALL be high from after E0 until the edge that asserts done; busy and done never high together.
REQ-021 Signed mode: quotient SHALL truncate toward zero (negated iff operand signs differ); remainder SHALL carry dividend sign.
REQ-022 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative, remainder = 0, no extra flag.
REQ-023 divisor == 0 at start SHALL bypass CALC: at E1 quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, done = 1, busy low throughout.
REQ-024 div_by_zero SHALL be 0 for every non-zero-divisor result.
REQ-025 quotient, remainder, div_by_zero SHALL hold until the next accepted start completes.
REQ-026 A start asserted in the same cycle done is high SHALL be accepted (state is IDLE then).
REQ-027 Input changes after E0 SHALL NOT affect the running operation.

Reset
REQ-028 rst_n low at an edge SHALL set state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, counter 0.
REQ-029 Reset mid-CALC/FIX SHALL abandon the operation; no done pulse SHALL follow.
REQ-030 start in the same cycle as rst_n low SHALL be ignored.

Verification
REQ-031 unsigned 100 / 7 -> done exactly 33 cycles after start; quotient 14, remainder 2, div_by_zero 0.
REQ-032 signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-033 signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-034 0x1234 / 0 (either mode) -> done 1 cycle after start; quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1.
REQ-035 start pulsed again at cycle 10 of a divide with new operands -> ignored; first result returned at cycle 33; start with done high -> new divide accepted.
REQ-036 rst_n low at cycle 15 of a divide -> all outputs 0, no done pulse; following 9 / 3 -> quotient 3, remainder 0.
